// File: rtl/revaluate_slice_streamer.sv
// revaluate_slice_streamer
// Drives the re-evaluation file reader and streams each 1600-bit state it
// returns to the downstream datapath. The state goes out as 64 slices of
// 25 bits over a valid/ready handshake. Files 0..num_files-1 are handled
// one at a time: request, wait one cycle, capture, then stream 64 slices.
module revaluate_slice_streamer #(
  parameter int SLICES  = 64,
  parameter int SLICE_W = 25,
  parameter int IDX_W   = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [IDX_W-1:0]            num_files,
  output logic                        read_file,
  output logic [IDX_W-1:0]            file_index,
  input  logic [SLICES*SLICE_W-1:0]   state_in,
  output logic [SLICE_W-1:0]          slice_out,
  output logic [$clog2(SLICES)-1:0]   slice_idx,
  output logic                        slice_valid,
  input  logic                        slice_ready,
  output logic                        busy,
  output logic                        done
);

  localparam int SIDX_W = $clog2(SLICES);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    STREAM,
    DONE
  } state_t;

  state_t                           state;
  logic [IDX_W-1:0]                 num_latched;
  logic [SLICES-1:0][SLICE_W-1:0]   hold;
  logic                             last_slice;
  logic                             last_file;

  // The holding register is viewed as an array of slices, so the current
  // slice is a plain index. Because it comes only from registers, it stays
  // stable for as long as slice_valid is held.
  assign slice_out  = hold[slice_idx];
  assign last_slice = (slice_idx == SIDX_W'(SLICES - 1));
  assign last_file  = (file_index == num_latched - 1'b1);

  // Sequencer FSM with registered outputs. The capture happens on the
  // WAIT->STREAM edge, one edge after the reader loads on the REQ->WAIT edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      num_latched <= '0;
      hold        <= '0;
      read_file   <= 1'b0;
      file_index  <= '0;
      slice_idx   <= '0;
      slice_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      read_file <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            num_latched <= num_files;
            file_index  <= '0;
            busy        <= 1'b1;
            if (num_files != '0) begin
              state     <= REQ;
              read_file <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        REQ: begin
          state <= WAIT;
        end
        WAIT: begin
          state       <= STREAM;
          hold        <= state_in;
          slice_idx   <= '0;
          slice_valid <= 1'b1;
        end
        STREAM: begin
          if (slice_ready) begin
            if (!last_slice) begin
              slice_idx <= slice_idx + 1'b1;
            end else begin
              slice_idx   <= '0;
              slice_valid <= 1'b0;
              if (!last_file) begin
                file_index <= file_index + 1'b1;
                read_file  <= 1'b1;
                state      <= REQ;
              end else begin
                done  <= 1'b1;
                state <= DONE;
              end
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_revaluate_slice_streamer.sv
// Testbench for revaluate_slice_streamer.
// A behavioural file reader supplies states where line k of file f holds
// 1000*f+k. Each run pushes its expected slices into a scoreboard queue,
// and a monitor pops one entry for every handshake it observes.
module tb_revaluate_slice_streamer;

  localparam int SLICES  = 64;
  localparam int SLICE_W = 25;
  localparam int IDX_W   = 10;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       start;
  logic [IDX_W-1:0]           num_files;
  logic                       read_file;
  logic [IDX_W-1:0]           file_index;
  logic [SLICES*SLICE_W-1:0]  state_in;
  logic [SLICE_W-1:0]         slice_out;
  logic [5:0]                 slice_idx;
  logic                       slice_valid;
  logic                       slice_ready;
  logic                       busy;
  logic                       done;

  typedef struct {
    int              file;
    int              idx;
    logic [24:0]     val;
  } exp_t;

  exp_t         sb_q[$];
  exp_t         mon_e;
  int           check_count = 0;
  int           pass_count  = 0;
  int           cyc = 0;
  int           rf_count, done_count, busy_count, done_cyc, start_cyc;
  int           rf_cyc_q[$];
  bit           random_ready = 1'b0;
  logic [15:0]  lfsr = 16'hACE1;
  bit           hold_pending = 1'b0;
  logic [5:0]   held_idx;
  logic [24:0]  held_out;

  revaluate_slice_streamer #(
    .SLICES(SLICES), .SLICE_W(SLICE_W), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_files(num_files),
    .read_file(read_file), .file_index(file_index), .state_in(state_in),
    .slice_out(slice_out), .slice_idx(slice_idx), .slice_valid(slice_valid),
    .slice_ready(slice_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Count clock edges; this is the time base for the latency checks.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [SLICES*SLICE_W-1:0] make_state(input int f);
    logic [SLICES*SLICE_W-1:0] s;
    s = '0;
    for (int k = 0; k < SLICES; k++) s[k*SLICE_W +: SLICE_W] = SLICE_W'(1000*f + k);
    return s;
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    check_count++;
    if (actual == expected) pass_count++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
  endtask

  // Behavioural file reader: loads the requested file while read_file is high.
  initial begin
    state_in = '0;
    forever begin
      @(negedge clk);
      if (read_file) state_in = make_state(int'(file_index));
    end
  end

  // slice_ready driver: tied high, or an LFSR pattern for the back-pressure run.
  initial begin
    slice_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (random_ready) begin
        lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        slice_ready = lfsr[0];
      end else begin
        slice_ready = 1'b1;
      end
    end
  end

  // Monitor: count strobes, check that slices are stable under back-pressure,
  // and score every handshake against the queue.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_pending = 1'b0;
      end else begin
        if (read_file) begin
          rf_count++;
          rf_cyc_q.push_back(cyc);
        end
        if (done) begin
          done_count++;
          done_cyc = cyc;
        end
        if (busy) busy_count++;
        if (hold_pending) begin
          checkOutput("hold_valid", longint'(slice_valid), 1);
          checkOutput("hold_idx", longint'(slice_idx), longint'(held_idx));
          checkOutput("hold_out", longint'(slice_out), longint'(held_out));
        end
        if (slice_valid && slice_ready) begin
          hold_pending = 1'b0;
          if (sb_q.size() == 0) begin
            checkOutput("unexpected_slice", 1, 0);
          end else begin
            mon_e = sb_q.pop_front();
            checkOutput("file_index", longint'(file_index), longint'(mon_e.file));
            checkOutput("slice_idx", longint'(slice_idx), longint'(mon_e.idx));
            checkOutput("slice_out", longint'(slice_out), longint'(mon_e.val));
          end
        end else if (slice_valid) begin
          hold_pending = 1'b1;
          held_idx     = slice_idx;
          held_out     = slice_out;
        end else begin
          hold_pending = 1'b0;
        end
      end
    end
  end

  // Queue the expected slices, clear the run counters, and pulse start.
  task automatic applyStimulus(input int nf);
    exp_t e;
    for (int f = 0; f < nf; f++) begin
      for (int k = 0; k < SLICES; k++) begin
        e.file = f;
        e.idx  = k;
        e.val  = 25'(1000*f + k);
        sb_q.push_back(e);
      end
    end
    rf_count   = 0;
    done_count = 0;
    busy_count = 0;
    done_cyc   = -1;
    rf_cyc_q.delete();
    @(posedge clk);
    #1;
    start     = 1'b1;
    num_files = IDX_W'(nf);
    @(posedge clk);
    #1;
    start_cyc = cyc;
    start     = 1'b0;
  endtask

  // Wait for the run to finish, then check the strobe counts and, when the
  // stream was not back-pressured, the exact cycle timing.
  task automatic finishRun(input string tag, input int nf, input bit timed);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while (!(done_count > 0 && !busy) && n < 2000);
    checkOutput({tag, "_timeout"}, longint'(n >= 2000), 0);
    checkOutput({tag, "_sb_empty"}, sb_q.size(), 0);
    checkOutput({tag, "_read_file_count"}, rf_count, nf);
    checkOutput({tag, "_done_count"}, done_count, 1);
    if (timed) begin
      checkOutput({tag, "_busy_cycles"}, busy_count, 66*nf + 1);
      checkOutput({tag, "_done_cycle"}, done_cyc, start_cyc + 66*nf);
      for (int i = 0; i < rf_cyc_q.size(); i++)
        checkOutput({tag, "_read_file_cycle"}, rf_cyc_q[i], start_cyc + 66*i);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_read_file"}, longint'(read_file), 0);
    checkOutput({tag, "_file_index"}, longint'(file_index), 0);
    checkOutput({tag, "_slice_idx"}, longint'(slice_idx), 0);
    checkOutput({tag, "_slice_valid"}, longint'(slice_valid), 0);
    checkOutput({tag, "_slice_out"}, longint'(slice_out), 0);
    checkOutput({tag, "_busy"}, longint'(busy), 0);
    checkOutput({tag, "_done"}, longint'(done), 0);
  endtask

  // Global time bound so the bench always ends.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $fatal(1, "[TB] global timeout");
  end

  // Directed test sequence.
  initial begin
    int n;
    rst       = 1'b0;
    start     = 1'b0;
    num_files = '0;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    #2 rst = 1'b0;

    $display("[TB] single file, ready high");
    applyStimulus(1);
    finishRun("one_file", 1, 1'b1);

    $display("[TB] three files, ready high");
    applyStimulus(3);
    finishRun("three_files", 3, 1'b1);

    $display("[TB] single file, pseudo-random ready");
    random_ready = 1'b1;
    applyStimulus(1);
    finishRun("random_ready", 1, 1'b0);
    random_ready = 1'b0;

    $display("[TB] zero files");
    applyStimulus(0);
    finishRun("zero_files", 0, 1'b1);

    $display("[TB] start while busy is ignored");
    applyStimulus(2);
    repeat (30) @(posedge clk);
    #1;
    start     = 1'b1;
    num_files = 10'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    finishRun("start_busy", 2, 1'b1);

    $display("[TB] async reset mid-stream");
    applyStimulus(2);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(slice_valid && file_index == 10'd1 && slice_idx == 6'd20) && n < 1000);
    checkOutput("reset_point_reached", longint'(n < 1000), 1);
    #2 rst = 1'b1;
    #1;
    checkResetOutputs("mid_reset");
    sb_q.delete();
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    applyStimulus(1);
    finishRun("after_reset", 1, 1'b1);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/revaluate_slice_streamer.md
Name: revaluate_slice_streamer

Overview:
- Sequencer directly upstream and downstream of the re-evaluation file reader (read_file / file_index / 1600-bit data_out).
- Requests PERE files 0..num_files-1 from the reader, one at a time.
- Captures each 1600-bit state into a holding register.
- Streams the state to the downstream re-evaluation datapath as 64 slices of 25 bits, over a valid/ready handshake.

Parameters:
- SLICES, 64, slices per state; slice k = state bits [25k+24:25k].
- SLICE_W, 25, bits per slice.
- IDX_W, 10, width of file_index and num_files.

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a run; sampled only in IDLE.
- num_files  input  IDX_W  files in the run; sampled on start.
- read_file  output  1  load strobe to the file reader; one cycle per file.
- file_index  output  IDX_W  index of the file being requested or streamed.
- state_in  input  SLICES*SLICE_W  1600-bit state from the file reader.
- slice_out  output  SLICE_W  current slice of the captured state.
- slice_idx  output  6  index of slice_out, 0..63.
- slice_valid  output  1  slice_out/slice_idx valid.
- slice_ready  input  1  downstream accepts the slice.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the run completes.

Behaviour:
- Reset (async, any state): state=IDLE; read_file=0, file_index=0, slice_idx=0, slice_valid=0, busy=0, done=0; holding register cleared, so slice_out=0.
- FSM states: IDLE, REQ, WAIT, STREAM, DONE.
- IDLE:
  - start=1 and num_files!=0 -> REQ; latch num_files; file_index=0.
  - start=1 and num_files==0 -> DONE with no file request.
- REQ: read_file=1 for exactly this cycle; -> WAIT. The reader loads its memory on the edge that ends REQ.
- WAIT: read_file=0; -> STREAM.
  - On the WAIT->STREAM edge, capture state_in into the holding register and set slice_idx=0.
  - Capture is one edge after the reader load, which avoids a same-edge race.
- STREAM:
  - slice_valid=1.
  - slice_out = hold[25*slice_idx +: 25], combinational from registers, stable while valid.
  - A transfer occurs on an edge with slice_valid && slice_ready.
  - slice_valid/slice_out/slice_idx must not change until the transfer.
  - Transfer with slice_idx<63: slice_idx+1.
  - Transfer with slice_idx==63 and file_index<num_files-1: file_index+1, slice_idx=0, -> REQ. slice_valid drops for the REQ and WAIT cycles.
  - Transfer with slice_idx==63 and file_index==num_files-1: -> DONE.
- DONE: done=1 for one cycle; -> IDLE.
  - file_index holds its last value until the next start.
  - slice_valid=0.
- start while busy: ignored. num_files changes while busy: ignored, because the latched copy is used.
- Latency with slice_ready tied high:
  - start sampled at edge E0; read_file high E0->E1; capture at E2.
  - First slice transfers at E3; slice 63 at E66.
  - Each further file costs 66 cycles: REQ + WAIT + 64 transfers.
- slice_ready low holds the stream with no data loss and no duplicated index.
- num_files=1023, the maximum: file_index reaches 1022 with no wrap.
- Reset asserted mid-STREAM: outputs return to reset values immediately; the next start restarts at file 0, slice 0.

Test Plan:
- Reset, start with num_files=1, file 0_PERE.txt where line k = k (25-bit), slice_ready=1 -> read_file high one cycle after start; 64 transfers with slice_out=k at slice_idx=k; done pulses one cycle after the slice-63 transfer; busy high 67 cycles.
- num_files=3, files where line k = 1000*f+k -> file_index steps 0,1,2; read_file pulses exactly 3 times, 66 cycles apart; all 192 slices in order; one done pulse.
- slice_ready toggled in a pseudo-random pattern (≈50%) on a 1-file run -> every slice accepted exactly once, in order; slice_out stable while valid && !ready.
- start with num_files=0 -> read_file never asserts; done pulses on the cycle after IDLE is left; busy high exactly 1 cycle.
- Async rst asserted mid-STREAM at slice_idx=20 of file 1 (num_files=2) -> outputs zero immediately; new start replays from file 0, slice 0.
- start pulsed again during STREAM with a different num_files -> no effect; the run completes with the original count.
